press_generator: RTL

PRESS_GENERATOR -- requirements
Module: press_generator

---
 rtl/press_generator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/press_generator.sv
// Press generator: turns single-cycle requests into fixed-width press pulses
// separated by a minimum gap, queueing requests that arrive while busy.
module press_generator #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              press_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              done,
    output logic              overflow
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]     HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              press_q, press_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic last;
    logic deq;
    logic direct;
    logic enq;

    assign last = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        deq     = 1'b0;
        direct  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = HOLD;
                    timer_d = HOLD_LD;
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = GAP;
                    timer_d = GAP_LD;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (last) begin
                    // Queued work takes priority; a fresh req is only
                    // consumed directly when nothing is waiting.
                    if (pend_q != '0) begin
                        state_d = HOLD;
                        timer_d = HOLD_LD;
                        deq     = 1'b1;
                    end else if (req) begin
                        state_d = HOLD;
                        timer_d = HOLD_LD;
                        direct  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign enq = req && (state_q != IDLE) && !direct;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        unique case ({enq, deq})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    assign press_d = (state_d == HOLD);
    assign busy_d  = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            press_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            press_q <= press_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign press_out = press_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

    // Nothing may be left queued once the block has gone idle.
    a_idle_empty: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE) |-> (pend_q == '0));

    a_busy_state: assert property (@(posedge clk) disable iff (reset)
        busy_q == (state_q != IDLE));

endmodule
